pc_next_address_unit: RTL and testbench

//  MIPS fetch-stage program counter with next-address logic. Holds the
//  32-bit instruction address and advances it each clock edge.
//  - select=0: PC+4 (sequential fetch).
//  - select=1: PC+4+(jump_steps<<2) (PC-relative branch).

---
 rtl/pc_next_address_unit.sv | 83 ++++++++
 tb/tb_pc_next_address_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_address_unit.sv
// MIPS fetch-stage program counter with next-address logic.
// The PC register feeds two ripple-carry adders built from 1-bit full adders.
// The first adder forms PC+INC. The second adds the shifted branch offset to that result.
// A 2:1 mux picks the sequential or branch target, and that choice loads the PC on every rising edge.
module pc_next_address_unit #(
    parameter int              WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter int              INC        = 4,
    parameter int              SHIFT      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] jump_steps,
    input  logic             select,
    output logic [WIDTH-1:0] current_address,
    output logic [WIDTH-1:0] address_plus4,
    output logic [WIDTH-1:0] jump_address
);

    // Sequential increment as a WIDTH-bit operand for the first adder.
    localparam logic [WIDTH-1:0] INC_VALUE = WIDTH'(INC);

    // Branch offset in bytes. The top SHIFT bits of jump_steps fall off the end.
    logic [WIDTH-1:0] byte_offset;

    // Carry into each bit position of the two ripple chains.
    logic [WIDTH-1:0] inc_carry;
    logic [WIDTH-1:0] jump_carry;

    // Mux output that is loaded into the PC on the next edge.
    logic [WIDTH-1:0] next_address;

    // Convert the signed instruction count into a byte offset with a logical left shift.
    always_comb begin
        byte_offset = jump_steps << SHIFT;
    end

    // Both adders start with a zero carry-in.
    assign inc_carry[0]  = 1'b0;
    assign jump_carry[0] = 1'b0;

    // First ripple-carry chain: address_plus4 = current_address + INC.
    // The MSB stage forms only its sum bit, because the final carry-out is
    // discarded and the result wraps modulo 2^WIDTH.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_inc_adder
            assign address_plus4[i] = current_address[i] ^ INC_VALUE[i] ^ inc_carry[i];
            if (i < WIDTH - 1) begin : g_inc_carry
                assign inc_carry[i+1] = (current_address[i] & INC_VALUE[i])
                                      | (inc_carry[i] & (current_address[i] ^ INC_VALUE[i]));
            end
        end
    endgenerate

    // Second ripple-carry chain: jump_address = address_plus4 + byte_offset.
    // Negative offsets work through two's complement wrap-around.
    genvar j;
    generate
        for (j = 0; j < WIDTH; j++) begin : g_jump_adder
            assign jump_address[j] = address_plus4[j] ^ byte_offset[j] ^ jump_carry[j];
            if (j < WIDTH - 1) begin : g_jump_carry
                assign jump_carry[j+1] = (address_plus4[j] & byte_offset[j])
                                       | (jump_carry[j] & (address_plus4[j] ^ byte_offset[j]));
            end
        end
    endgenerate

    // 2:1 next-address mux: sequential fetch when select is low, branch target when it is high.
    always_comb begin
        next_address = select ? jump_address : address_plus4;
    end

    // PC register. It clears asynchronously while reset is low and otherwise advances on every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_address <= RESET_ADDR;
        end else begin
            current_address <= next_address;
        end
    end

endmodule

// File: tb/tb_pc_next_address_unit.sv
// Scoreboard bench for pc_next_address_unit.
// The bench pushes each expected next PC when it drives inputs on a falling edge.
// It pops and compares that value 1 ns after the following rising edge.
module tb_pc_next_address_unit;

    logic        clk;
    logic        reset;
    logic [31:0] jump_steps;
    logic        select;
    logic [31:0] current_address;
    logic [31:0] address_plus4;
    logic [31:0] jump_address;

    int          n_checks;
    int          n_fail;
    logic [31:0] sb[$];
    logic [31:0] model_pc;
    logic [31:0] model_next;
    logic [31:0] exp;

    pc_next_address_unit #(
        .WIDTH(32),
        .RESET_ADDR(32'h0),
        .INC(4),
        .SHIFT(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .jump_steps(jump_steps),
        .select(select),
        .current_address(current_address),
        .address_plus4(address_plus4),
        .jump_address(jump_address)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got no summary, required completion");
        $fatal(1);
    end

    // Drive inputs on the falling edge and queue the PC expected after the next rising edge
    task automatic drive_inputs(input logic rst, input logic sel, input logic [31:0] js);
        @(negedge clk);
        reset      = rst;
        select     = sel;
        jump_steps = js;
        if (!rst) begin
            model_pc   = 32'h0;
            model_next = 32'h0;
        end else if (sel) begin
            model_next = model_pc + 32'd4 + (js << 2);
        end else begin
            model_next = model_pc + 32'd4;
        end
        sb.push_back(model_next);
        #1;
    endtask

    // Advance through one rising edge and settle
    task automatic clock_edge;
        @(posedge clk);
        #1;
        model_pc = model_next;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            drive_inputs(1'b0, 1'b0, 32'h0);
            n_checks++;
            if (current_address !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_hold_pc: got %h, required %h", current_address, 32'h0);
            end
            n_checks++;
            if (address_plus4 !== 32'h4) begin
                n_fail++;
                $display("[TB] FAIL reset_hold_plus4: got %h, required %h", address_plus4, 32'h4);
            end
            clock_edge();
            exp = sb.pop_front();
            n_checks++;
            if (current_address !== exp) begin
                n_fail++;
                $display("[TB] FAIL reset_edge_pc: got %h, required %h", current_address, exp);
            end
        end
        // Release the reset, take one edge, and then assert reset in the middle of the cycle
        drive_inputs(1'b1, 1'b0, 32'h0);
        clock_edge();
        exp = sb.pop_front();
        n_checks++;
        if (current_address !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_release_pc: got %h, required %h", current_address, exp);
        end
        @(negedge clk);
        #2;
        reset    = 1'b0;
        model_pc = 32'h0;
        #1;
        n_checks++;
        if (current_address !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_async_clear: got %h, required %h", current_address, 32'h0);
        end
    endtask

    task automatic test_sequential;
        for (int k = 0; k < 5; k++) begin
            drive_inputs(1'b1, 1'b0, 32'h0);
            n_checks++;
            if (address_plus4 !== model_pc + 32'd4) begin
                n_fail++;
                $display("[TB] FAIL seq_plus4: got %h, required %h", address_plus4, model_pc + 32'd4);
            end
            clock_edge();
            exp = sb.pop_front();
            n_checks++;
            if (current_address !== exp) begin
                n_fail++;
                $display("[TB] FAIL seq_pc: got %h, required %h", current_address, exp);
            end
        end
        n_checks++;
        if (current_address !== 32'd20) begin
            n_fail++;
            $display("[TB] FAIL seq_final: got %h, required %h", current_address, 32'd20);
        end
    endtask

    task automatic test_branch;
        drive_inputs(1'b1, 1'b1, 32'd100);
        n_checks++;
        if (jump_address !== 32'd424) begin
            n_fail++;
            $display("[TB] FAIL branch_target: got %h, required %h", jump_address, 32'd424);
        end
        clock_edge();
        exp = sb.pop_front();
        n_checks++;
        if (current_address !== exp) begin
            n_fail++;
            $display("[TB] FAIL branch_pc: got %h, required %h", current_address, exp);
        end
        drive_inputs(1'b1, 1'b0, 32'd100);
        clock_edge();
        exp = sb.pop_front();
        n_checks++;
        if (current_address !== exp) begin
            n_fail++;
            $display("[TB] FAIL branch_after_seq: got %h, required %h", current_address, exp);
        end
    endtask

    task automatic test_second_branch;
        for (int k = 0; k < 3; k++) begin
            drive_inputs(1'b1, 1'b0, 32'h0);
            clock_edge();
            exp = sb.pop_front();
            n_checks++;
            if (current_address !== exp) begin
                n_fail++;
                $display("[TB] FAIL branch2_walk: got %h, required %h", current_address, exp);
            end
        end
        drive_inputs(1'b1, 1'b1, 32'd10);
        n_checks++;
        if (jump_address !== model_pc + 32'd4 + 32'd40) begin
            n_fail++;
            $display("[TB] FAIL branch2_target: got %h, required %h", jump_address, model_pc + 32'd44);
        end
        clock_edge();
        for (int k = 0; k < 3; k++) begin
            exp = sb.pop_front();
            n_checks++;
            if (current_address !== exp) begin
                n_fail++;
                $display("[TB] FAIL branch2_pc: got %h, required %h", current_address, exp);
            end
            if (k < 2) begin
                drive_inputs(1'b1, 1'b0, 32'd10);
                clock_edge();
            end
        end
        n_checks++;
        if (current_address !== 32'd492) begin
            n_fail++;
            $display("[TB] FAIL branch2_final: got %h, required %h", current_address, 32'd492);
        end
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        #2;
        reset    = 1'b0;
        select   = 1'b1;
        model_pc = 32'h0;
        #1;
        n_checks++;
        if (current_address !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL midrun_clear: got %h, required %h", current_address, 32'h0);
        end
        for (int k = 0; k < 2; k++) begin
            drive_inputs(1'b0, 1'b1, 32'd5);
            clock_edge();
            exp = sb.pop_front();
            n_checks++;
            if (current_address !== exp) begin
                n_fail++;
                $display("[TB] FAIL midrun_hold: got %h, required %h", current_address, exp);
            end
        end
        drive_inputs(1'b1, 1'b0, 32'd5);
        clock_edge();
        exp = sb.pop_front();
        n_checks++;
        if (current_address !== 32'd4 || current_address !== exp) begin
            n_fail++;
            $display("[TB] FAIL midrun_release: got %h, required %h", current_address, exp);
        end
    endtask

    task automatic test_negative_wrap;
        logic [31:0] js_list[4];
        logic        sel_list[4];
        js_list  = '{32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0};
        sel_list = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            drive_inputs(1'b1, sel_list[k], js_list[k]);
            clock_edge();
            exp = sb.pop_front();
            n_checks++;
            if (current_address !== exp) begin
                n_fail++;
                $display("[TB] FAIL negwrap_pc_%0d: got %h, required %h", k, current_address, exp);
            end
            n_checks++;
            if (address_plus4 !== exp + 32'd4) begin
                n_fail++;
                $display("[TB] FAIL negwrap_plus4_%0d: got %h, required %h", k, address_plus4, exp + 32'd4);
            end
        end
    endtask

    task automatic test_shift_drop;
        drive_inputs(1'b1, 1'b1, 32'h4000_0001);
        n_checks++;
        if (jump_address !== model_pc + 32'd8) begin
            n_fail++;
            $display("[TB] FAIL shiftdrop_target: got %h, required %h", jump_address, model_pc + 32'd8);
        end
        clock_edge();
        exp = sb.pop_front();
        n_checks++;
        if (current_address !== exp) begin
            n_fail++;
            $display("[TB] FAIL shiftdrop_pc: got %h, required %h", current_address, exp);
        end
        drive_inputs(1'b1, 1'b1, 32'hC000_0000);
        clock_edge();
        exp = sb.pop_front();
        n_checks++;
        if (current_address !== exp) begin
            n_fail++;
            $display("[TB] FAIL shiftdrop_zero: got %h, required %h", current_address, exp);
        end
    endtask

    task automatic test_back_to_back;
        logic        sel;
        logic [31:0] js;
        for (int k = 0; k < 12; k++) begin
            sel = 1'($urandom_range(0, 1));
            js  = 32'($urandom_range(0, 400)) - 32'd200;
            drive_inputs(1'b1, sel, js);
            n_checks++;
            if (jump_address !== model_pc + 32'd4 + (js << 2)) begin
                n_fail++;
                $display("[TB] FAIL b2b_target: got %h, required %h", jump_address, model_pc + 32'd4 + (js << 2));
            end
            clock_edge();
            exp = sb.pop_front();
            n_checks++;
            if (current_address !== exp) begin
                n_fail++;
                $display("[TB] FAIL b2b_pc: got %h, required %h", current_address, exp);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        select     = 1'b0;
        jump_steps = 32'h0;
        model_pc   = 32'h0;
        model_next = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_second_branch();
        test_reset_mid_run();
        test_negative_wrap();
        test_shift_drop();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
